// File: rtl/spi_pkg.sv
// SPI write-controller shared types and constants.
// Frame layout, register map and FSM state encoding.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic WRITE_BIT = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_OUT_7_0   = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_OUT_15_8  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_PWM_7_0   = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_PWM_15_8  = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } state_e;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request handshake between a register-write client
// and the SPI controller.
interface spi_controller_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/spi_sclk_divider.sv
// Half-period tick generator for SCLK; free-runs only
// while enabled and restarts from zero otherwise.
module spi_sclk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = 8'd0;
    if (en && cnt_q != DIV_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == DIV_MAX);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: one 16-bit write frame
// per accepted request, then a minimum nCS-high gap.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_controller_if.slave req,
  output logic            nCS,
  output logic            SCLK,
  output logic            COPI,
  output logic            busy,
  output logic            done
);

  localparam logic [7:0] GAP_MAX  = 8'(CS_IDLE - 1);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_W);

  state_e             state_q;
  state_e             state_d;
  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] shift_d;
  logic [4:0]         bit_q;
  logic [4:0]         bit_d;
  logic [7:0]         gap_q;
  logic [7:0]         gap_d;
  logic               sclk_q;
  logic               sclk_d;
  logic               done_q;
  logic               done_d;
  logic               active;
  logic               tick;

  assign active = (state_q == ST_SETUP) ||
                  (state_q == ST_SHIFT);

  spi_sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req.req_valid) begin
          state_d = ST_SETUP;
          shift_d = make_frame(req.req_addr,
                               req.req_data);
          bit_d   = 5'd0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          // Falling edge advances data; a low phase ends
          // either in the next rise or in the gap.
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
            bit_d   = bit_q + 5'd1;
          end else if (bit_q == LAST_BIT) begin
            state_d = ST_GAP;
            gap_d   = 8'd0;
          end else begin
            sclk_d  = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= 5'd0;
      gap_q   <= 8'd0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  assign req.req_ready = (state_q == ST_IDLE);
  assign nCS  = ~active;
  assign SCLK = sclk_q;
  assign COPI = active & shift_q[FRAME_W-1];
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (div 4/gap 4
// and div 2/gap 1), a frame scoreboard and a register model.
module tb_spi_controller;

  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_controller_if bus0 ();
  spi_controller_if bus1 ();

  logic ncs0, sclk0, copi0, busy0, done0;
  logic ncs1, sclk1, copi1, busy1, done1;

  spi_controller #(.CLK_DIV(4), .CS_IDLE(4)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus0),
    .nCS  (ncs0),
    .SCLK (sclk0),
    .COPI (copi0),
    .busy (busy0),
    .done (done0)
  );

  spi_controller #(.CLK_DIV(2), .CS_IDLE(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus1),
    .nCS  (ncs1),
    .SCLK (sclk1),
    .COPI (copi1),
    .busy (busy1),
    .done (done1)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [7:0]  regs[128];

  int done_cnt[2];
  int done_cyc[2];
  int frames[2];
  int last_gap[2];
  int last_acc[2];

  // {nCS, SCLK, COPI, done, busy, req_ready}
  function automatic logic [5:0] pins(input int i);
    if (i == 0)
      return {ncs0, sclk0, copi0, done0, busy0,
              bus0.req_ready};
    return {ncs1, sclk1, copi1, done1, busy1,
            bus1.req_ready};
  endfunction

  task automatic drive(input int i, input logic v,
                       input logic [6:0] a,
                       input logic [7:0] d);
    if (i == 0) begin
      bus0.req_valid = v;
      bus0.req_addr  = a;
      bus0.req_data  = d;
    end else begin
      bus1.req_valid = v;
      bus1.req_addr  = a;
      bus1.req_data  = d;
    end
  endtask

  task automatic monitor(input int i);
    int d;
    int rises;
    int low_len;
    int gap_len;
    bit stable;
    logic held;
    logic pn;
    logic ps;
    logic [5:0] p;
    logic [15:0] sh;
    logic [15:0] exp;
    d = (i == 0) ? 4 : 2;
    pn = 1'b1;
    ps = 1'b0;
    rises = 0;
    low_len = 0;
    gap_len = 1000;
    stable = 1'b1;
    held = 1'b0;
    sh = '0;
    forever begin
      @(negedge clk);
      p = pins(i);
      if (p[2]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (!p[5]) begin
        if (pn) begin
          rises = 0;
          low_len = 0;
          stable = 1'b1;
          sh = '0;
          last_gap[i] = gap_len;
        end
        low_len++;
        if (p[4] && !ps) begin
          rises++;
          sh = {sh[14:0], p[3]};
          held = p[3];
        end else if (p[4] && p[3] !== held) begin
          stable = 1'b0;
        end
      end else begin
        gap_len = pn ? gap_len + 1 : 1;
        if (!pn && rst_n) begin
          frames[i]++;
          if (i == 0 && sh[15])
            regs[sh[14:8]] = sh[7:0];
          tests++;
          if (i == 0 && exp_q0.size() > 0)
            exp = exp_q0.pop_front();
          else if (i == 1 && exp_q1.size() > 0)
            exp = exp_q1.pop_front();
          else
            exp = 16'hxxxx;
          if (sh !== exp) begin
            fails++;
            $display("FAIL frame%0d: got %h want %h",
                     i, sh, exp);
          end
          tests++;
          if (rises != 16) begin
            fails++;
            $display("FAIL rises%0d: got %0d want 16",
                     i, rises);
          end
          tests++;
          if (low_len != 33 * d) begin
            fails++;
            $display("FAIL ncs_low%0d: got %0d want %0d",
                     i, low_len, 33 * d);
          end
          tests++;
          if (!stable) begin
            fails++;
            $display("FAIL copi_stable%0d: got 0 want 1",
                     i);
          end
        end
      end
      pn = p[5];
      ps = p[4];
    end
  endtask

  task automatic accept(input int i,
                        input logic [6:0] a,
                        input logic [7:0] d);
    int n;
    logic [5:0] p;
    n = 0;
    drive(i, 1'b1, a, d);
    p = pins(i);
    while (!p[0] && n < TMO) begin
      @(negedge clk);
      n++;
      p = pins(i);
    end
    tests++;
    if (!p[0]) begin
      fails++;
      $display("FAIL accept%0d: ready 0 want 1", i);
    end else if (i == 0) begin
      exp_q0.push_back({1'b1, a, d});
    end else begin
      exp_q1.push_back({1'b1, a, d});
    end
    @(posedge clk);
    #1;
    last_acc[i] = cyc;
  endtask

  task automatic send(input int i,
                      input logic [6:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    accept(i, a, d);
    drive(i, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic wait_done(input int i,
                           input int target);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < TMO) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt[i] < target) begin
      fails++;
      $display("FAIL done_wait%0d: got %0d want %0d",
               i, done_cnt[i], target);
    end
  endtask

  task automatic test_reset;
    logic [5:0] p;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      p = pins(i);
      tests++;
      if (p[5:1] !== 5'b10000) begin
        fails++;
        $display("FAIL reset%0d: got %b want 10000",
                 i, p[5:1]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      p = pins(i);
      tests++;
      if (p[0] !== 1'b1) begin
        fails++;
        $display("FAIL ready_after_reset%0d: got %b want 1",
                 i, p[0]);
      end
    end
  endtask

  task automatic test_basic;
    int n0;
    n0 = done_cnt[0];
    send(0, 7'h04, 8'hA5);
    wait_done(0, n0 + 1);
    tests++;
    if (done_cyc[0] - last_acc[0] != 136) begin
      fails++;
      $display("FAIL latency0: got %0d want 136",
               done_cyc[0] - last_acc[0]);
    end
    repeat (20) @(negedge clk);
    tests++;
    if (done_cnt[0] != n0 + 1) begin
      fails++;
      $display("FAIL done_once: got %0d want %0d",
               done_cnt[0], n0 + 1);
    end
  endtask

  task automatic test_loopback;
    logic [6:0] a [4];
    logic [7:0] d [4];
    a = '{7'h00, 7'h02, 7'h04, 7'h7F};
    d = '{8'hFF, 8'h0F, 8'h80, 8'h3C};
    for (int k = 0; k < 4; k++) begin
      send(0, a[k], d[k]);
      wait_done(0, done_cnt[0] + 1);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (regs[a[k]] !== d[k]) begin
        fails++;
        $display("FAIL reg_%h: got %h want %h",
                 a[k], regs[a[k]], d[k]);
      end
    end
  endtask

  task automatic test_ignore;
    int n0;
    int f0;
    int bad;
    logic [5:0] p;
    n0 = done_cnt[0];
    f0 = frames[0];
    bad = 0;
    send(0, 7'h10, 8'h55);
    repeat (20) @(negedge clk);
    drive(0, 1'b1, 7'h01, 8'h99);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      p = pins(0);
      if (p[0] !== 1'b0) bad++;
    end
    drive(0, 1'b0, 7'h00, 8'h00);
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL busy_ready: high %0d cycles want 0",
               bad);
    end
    wait_done(0, n0 + 1);
    repeat (200) @(negedge clk);
    tests++;
    if (done_cnt[0] != n0 + 1 || frames[0] != f0 + 1) begin
      fails++;
      $display("FAIL ignore: done %0d frames %0d want 1 1",
               done_cnt[0] - n0, frames[0] - f0);
    end
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = done_cnt[0];
    @(negedge clk);
    accept(0, 7'h03, 8'h11);
    drive(0, 1'b1, 7'h04, 8'h22);
    @(negedge clk);
    accept(0, 7'h04, 8'h22);
    drive(0, 1'b0, 7'h00, 8'h00);
    wait_done(0, n0 + 2);
    tests++;
    if (last_gap[0] != 5) begin
      fails++;
      $display("FAIL b2b_gap: got %0d want 5",
               last_gap[0]);
    end
    repeat (10) @(negedge clk);
    tests++;
    if (done_cnt[0] != n0 + 2) begin
      fails++;
      $display("FAIL b2b_done: got %0d want 2",
               done_cnt[0] - n0);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    logic [5:0] p;
    n0 = done_cnt[0];
    send(0, 7'h02, 8'hC3);
    repeat (61) @(posedge clk);
    #1;
    p = pins(0);
    tests++;
    if (p[4] !== 1'b1 || p[5] !== 1'b0) begin
      fails++;
      $display("FAIL mid_state: ncs %b sclk %b want 0 1",
               p[5], p[4]);
    end
    rst_n = 1'b0;
    #1;
    p = pins(0);
    tests++;
    if (p[5] !== 1'b1 || p[4] !== 1'b0) begin
      fails++;
      $display("FAIL abort: ncs %b sclk %b want 1 0",
               p[5], p[4]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q0.delete();
    repeat (150) @(negedge clk);
    tests++;
    if (done_cnt[0] != n0) begin
      fails++;
      $display("FAIL abort_done: got %0d want 0",
               done_cnt[0] - n0);
    end
    send(0, 7'h01, 8'h5A);
    wait_done(0, n0 + 1);
    tests++;
    if (regs[1] !== 8'h5A) begin
      fails++;
      $display("FAIL post_reset_reg: got %h want 5a",
               regs[1]);
    end
  endtask

  task automatic test_fast;
    int n0;
    n0 = done_cnt[1];
    send(1, 7'h04, 8'h3C);
    wait_done(1, n0 + 1);
    tests++;
    if (done_cyc[1] - last_acc[1] != 67) begin
      fails++;
      $display("FAIL latency1: got %0d want 67",
               done_cyc[1] - last_acc[1]);
    end
    send(1, 7'h55, 8'h01);
    wait_done(1, n0 + 2);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) regs[k] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      done_cyc[k] = 0;
      frames[k] = 0;
      last_gap[k] = 0;
      last_acc[k] = 0;
    end
    drive(0, 1'b0, 7'h00, 8'h00);
    drive(1, 1'b0, 7'h00, 8'h00);
    fork
      monitor(0);
      monitor(1);
    join_none
    test_reset();
    test_basic();
    test_loopback();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    repeat (20) @(negedge clk);
    tests++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d/%0d want 0/0",
               exp_q0.size(), exp_q1.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-002 CS_IDLE, default 4, minimum nCS-high gap between frames in clk cycles; legal range 1..255.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  write request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_addr  input  7  target register address.
REQ-008 req_data  input  8  register write data.
REQ-009 nCS  output  1  SPI chip select, active-low.
REQ-010 SCLK  output  1  SPI clock, mode 0 (idle low).
REQ-011 COPI  output  1  SPI serial data to peripheral.
REQ-012 busy  output  1  frame in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse at frame completion.

Function
REQ-014 Frame SHALL be 16 bits, MSB first: bit15=1 (write), bits14:8=req_addr, bits7:0=req_data.
REQ-015 Handshake: transfer SHALL occur on a clk edge with req_valid && req_ready; addr/data captured into a 16-bit shift register on that edge.
REQ-016 req_ready SHALL be high only in IDLE; requests presented while busy SHALL be ignored, not queued.
REQ-017 FSM states: IDLE, SETUP, SHIFT, GAP.
REQ-018 IDLE -> SETUP on accept; nCS low and COPI=frame bit15 from the first SETUP cycle.
REQ-019 SETUP SHALL last CLK_DIV cycles with SCLK low, then -> SHIFT.
REQ-020 SHIFT: each bit SHALL be CLK_DIV cycles SCLK high followed by CLK_DIV cycles SCLK low; exactly 16 rising edges per frame.
REQ-021 COPI SHALL change only on the cycle SCLK goes low (next bit); stable throughout each SCLK-high phase.
REQ-022 A 5-bit bit counter SHALL count 0..16; after the 16th low phase, SHIFT -> GAP with nCS high, SCLK low, COPI low.
REQ-023 GAP SHALL hold nCS high CS_IDLE cycles, then -> IDLE with done high for exactly that one transition cycle.
REQ-024 nCS-low duration SHALL be exactly 33*CLK_DIV cycles; accept-to-done latency 33*CLK_DIV+CS_IDLE cycles.
REQ-025 With req_valid held high, back-to-back frames SHALL occur with one IDLE cycle plus CS_IDLE between them.
REQ-026 Addresses above 0x04 SHALL be transmitted unmodified; decode is the peripheral's responsibility.
REQ-027 Divider counter SHALL wrap at CLK_DIV-1; no SCLK edge outside SHIFT.

Reset
REQ-028 On rst_n low, asynchronously: state IDLE, nCS=1, SCLK=0, COPI=0, done=0, busy=0, counters and shift register 0.
REQ-029 req_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-030 Reset mid-frame SHALL abort the frame with no done pulse; nCS high immediately.

Structure
REQ-031 Shared package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, WRITE_BIT=1, and register address constants 0x00..0x04 (out_7_0, out_15_8, pwm_7_0, pwm_15_8, pwm_duty).
REQ-032 One sub-module spi_sclk_divider SHALL generate half-period tick pulses from CLK_DIV, enabled only in SETUP/SHIFT.

Verification
REQ-033 CLK_DIV=4: addr 0x04, data 0xA5 -> bits sampled at SCLK rise = 0x84A5, nCS low 132 cycles, done once.
REQ-034 Loopback to the SPI peripheral: writes 0x00<-0xFF, 0x02<-0x0F, 0x04<-0x80 -> peripheral registers read back those values.
REQ-035 req_valid pulsed during SHIFT with addr 0x01 -> ignored, no second frame, req_ready low throughout.
REQ-036 req_valid held, two requests -> nCS-high gap between frames = CS_IDLE+1 cycles, two done pulses.
REQ-037 rst_n low at bit 7 of a frame -> nCS=1, SCLK=0 same cycle, no done, next request produces a clean frame.
REQ-038 CLK_DIV=2, CS_IDLE=1 -> 16 SCLK rising edges, COPI stable across every high phase.
